// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: one bit per clock under start/busy/done.
// Ops: SLL, SRL, SRA, ROL; carry_out holds the last bit shifted out.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] count;
  logic [WIDTH-1:0] step_r;
  logic             step_c;
  logic             accept;

  assign accept = (state == IDLE) && start;

  always_comb begin
    step_r = result;
    step_c = 1'b0;
    unique case (op_q)
      OP_SLL: begin
        step_r = {result[WIDTH-2:0], 1'b0};
        step_c = result[WIDTH-1];
      end
      OP_SRL: begin
        step_r = {1'b0, result[WIDTH-1:1]};
        step_c = result[0];
      end
      OP_SRA: begin
        step_r = {result[WIDTH-1], result[WIDTH-1:1]};
        step_c = result[0];
      end
      OP_ROL: begin
        step_r = {result[WIDTH-2:0], result[WIDTH-1]};
        step_c = result[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (amount == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (count == AMT_W'(1))
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_SLL;
      count     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        result    <= data_in;
        op_q      <= op;
        count     <= amount;
        carry_out <= 1'b0;
      end else if (state == SHIFT) begin
        result    <= step_r;
        carry_out <= step_c;
        count     <= count - AMT_W'(1);
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed table plus corner sequences for seq_shifter,
// with an 8/32-bit random sweep against a behavioural model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] d;
  logic [4:0]  amount;

  logic        busy16, done16, c16;
  logic [15:0] r16;
  logic        busy8, done8, c8;
  logic [7:0]  r8;
  logic        busy32, done32, c32;
  logic [31:0] r32;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .AMT_W(5)) u16 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .data_in(d[15:0]), .amount(amount), .busy(busy16),
    .done(done16), .result(r16), .carry_out(c16)
  );

  seq_shifter #(.WIDTH(8), .AMT_W(5)) u8 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .data_in(d[7:0]), .amount(amount), .busy(busy8),
    .done(done8), .result(r8), .carry_out(c8)
  );

  seq_shifter #(.WIDTH(32), .AMT_W(5)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .data_in(d), .amount(amount), .busy(busy32),
    .done(done32), .result(r32), .carry_out(c32)
  );

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [4:0]  n;
    logic [15:0] exp_r;
    logic        exp_c;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model(input int w, input logic [1:0] o,
                                input logic [31:0] din, input int n,
                                output logic [31:0] r, output logic c);
    logic [31:0] mask;
    logic        top;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    r = din & mask;
    c = 1'b0;
    for (int i = 0; i < n; i++) begin
      top = r[w-1];
      case (o)
        2'b00: begin c = top; r = (r << 1) & mask; end
        2'b01: begin c = r[0]; r = r >> 1; end
        2'b10: begin
          c = r[0];
          r = (r >> 1) | (32'(top) << (w - 1));
        end
        default: begin
          c = top;
          r = ((r << 1) | 32'(top)) & mask;
        end
      endcase
    end
  endfunction

  // Start one op; poke>0 pulses a conflicting start at that cycle.
  task automatic run(input logic [1:0] o, input logic [31:0] din,
                     input logic [4:0] n, input int poke,
                     output int lat);
    @(negedge clk);
    op     = o;
    d      = din;
    amount = n;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done16 && lat < 80) begin
      if (lat == poke) begin
        start  = 1'b1;
        op     = 2'b00;
        d      = 32'h0000_1234;
        amount = 5'd1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end
    if (!done16) begin
      errors++;
      checks++;
      $display("FAIL timeout: done never rose, got %0d cycles", lat);
    end
  endtask

  task automatic idle_chk(input string name);
    @(posedge clk);
    #1;
    chk({name, "_busy_idle"}, {31'b0, busy16}, 32'd0);
    chk({name, "_done_pulse"}, {31'b0, done16}, 32'd0);
  endtask

  initial begin
    int          lat;
    logic [31:0] er;
    logic        ec;

    vecs[0]  = '{2'b00, 16'h0001, 5'd1,  16'h0002, 1'b0};
    vecs[1]  = '{2'b10, 16'h8000, 5'd4,  16'hF800, 1'b0};
    vecs[2]  = '{2'b01, 16'h8001, 5'd1,  16'h4000, 1'b1};
    vecs[3]  = '{2'b11, 16'h8001, 5'd1,  16'h0003, 1'b1};
    vecs[4]  = '{2'b11, 16'h1234, 5'd16, 16'h1234, 1'b0};
    vecs[5]  = '{2'b00, 16'hBEEF, 5'd0,  16'hBEEF, 1'b0};
    vecs[6]  = '{2'b01, 16'hFFFF, 5'd20, 16'h0000, 1'b0};
    vecs[7]  = '{2'b10, 16'h8000, 5'd20, 16'hFFFF, 1'b1};
    vecs[8]  = '{2'b00, 16'h8000, 5'd1,  16'h0000, 1'b1};
    vecs[9]  = '{2'b11, 16'h8000, 5'd17, 16'h0001, 1'b1};
    vecs[10] = '{2'b10, 16'h7FFE, 5'd3,  16'h0FFF, 1'b1};
    vecs[11] = '{2'b11, 16'h1234, 5'd4,  16'h2341, 1'b1};

    reset  = 1'b1;
    start  = 1'b0;
    op     = 2'b00;
    d      = '0;
    amount = '0;
    #12;
    chk("rst_busy",   {31'b0, busy16}, 32'd0);
    chk("rst_done",   {31'b0, done16}, 32'd0);
    chk("rst_result", {16'b0, r16},    32'd0);
    chk("rst_carry",  {31'b0, c16},    32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run(vecs[i].op, {16'b0, vecs[i].data}, vecs[i].n, 0, lat);
      chk($sformatf("v%0d_lat", i), lat, 32'(vecs[i].n) + 1);
      chk($sformatf("v%0d_busy", i), {31'b0, busy16}, 32'd1);
      chk($sformatf("v%0d_result", i), {16'b0, r16},
          {16'b0, vecs[i].exp_r});
      chk($sformatf("v%0d_carry", i), {31'b0, c16},
          {31'b0, vecs[i].exp_c});
      idle_chk($sformatf("v%0d", i));
      chk($sformatf("v%0d_hold", i), {16'b0, r16},
          {16'b0, vecs[i].exp_r});
    end

    run(2'b10, 32'h0000_8000, 5'd4, 2, lat);
    chk("busy_start_lat", lat, 32'd5);
    chk("busy_start_result", {16'b0, r16}, 32'h0000_F800);
    chk("busy_start_carry", {31'b0, c16}, 32'd0);
    idle_chk("busy_start");

    @(negedge clk);
    op     = 2'b00;
    d      = 32'h0000_FFFF;
    amount = 5'd10;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy",   {31'b0, busy16}, 32'd0);
    chk("mid_rst_done",   {31'b0, done16}, 32'd0);
    chk("mid_rst_result", {16'b0, r16},    32'd0);
    chk("mid_rst_carry",  {31'b0, c16},    32'd0);
    @(negedge clk);
    reset = 1'b0;
    run(2'b00, 32'h0000_0001, 5'd1, 0, lat);
    chk("post_rst_lat", lat, 32'd2);
    chk("post_rst_result", {16'b0, r16}, 32'h0000_0002);
    idle_chk("post_rst");

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] rd;
      logic [4:0]  rn;
      ro = 2'($urandom_range(0, 3));
      rd = $urandom;
      rn = 5'($urandom_range(0, 31));
      run(ro, rd, rn, 0, lat);
      chk($sformatf("rnd%0d_lat", i), lat, 32'(rn) + 1);
      chk($sformatf("rnd%0d_done8", i), {31'b0, done8}, 32'd1);
      chk($sformatf("rnd%0d_done32", i), {31'b0, done32}, 32'd1);
      model(8, ro, rd, int'(rn), er, ec);
      chk($sformatf("rnd%0d_r8", i), {24'b0, r8}, er);
      chk($sformatf("rnd%0d_c8", i), {31'b0, c8}, {31'b0, ec});
      model(16, ro, rd, int'(rn), er, ec);
      chk($sformatf("rnd%0d_r16", i), {16'b0, r16}, er);
      chk($sformatf("rnd%0d_c16", i), {31'b0, c16}, {31'b0, ec});
      model(32, ro, rd, int'(rn), er, ec);
      chk($sformatf("rnd%0d_r32", i), r32, er);
      chk($sformatf("rnd%0d_c32", i), {31'b0, c32}, {31'b0, ec});
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_idle", i),
          {29'b0, busy8, busy16, busy32}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
